// File: rtl/seanet_rbttx_deparser_arb.sv
// Round-robin front end for a shared deparser. One port is granted at a time;
// its PHV beat goes first, then its whole packet, and priority rotates only after tlast.
`timescale 1ns/1ps
module seanet_rbttx_deparser_arb #(
    parameter int PORTS      = 2,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 64,
    parameter int PHV_WIDTH  = 408,
    parameter int SEL_WIDTH  = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*PHV_WIDTH-1:0]  s_phv_info,
    input  logic [PORTS-1:0]            s_phv_valid,
    output logic [PORTS-1:0]            s_phv_ready,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    output logic [PORTS-1:0]            s_axis_tready,
    input  logic [PORTS-1:0]            s_axis_tlast,
    input  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser,
    output logic [PHV_WIDTH-1:0]        m_phv_info,
    output logic                        m_phv_valid,
    input  logic                        m_phv_ready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [USER_WIDTH-1:0]       m_axis_tuser,
    output logic [SEL_WIDTH-1:0]        grant_port,
    output logic                        busy
);

    typedef enum logic [1:0] {S_IDLE, S_PHV, S_PKT} state_t;

    state_t               state_q;
    logic [SEL_WIDTH-1:0] prio_q;
    logic [SEL_WIDTH-1:0] grant_q;
    logic                 busy_q;

    logic [SEL_WIDTH-1:0] win;
    logic                 win_vld;
    logic                 in_phv;
    logic                 in_pkt;
    logic                 phv_fire;
    logic                 pkt_end;
    logic [SEL_WIDTH-1:0] prio_d;

    // First PHV requester at or after prio, wrapping modulo PORTS
    always_comb begin
        int idx;
        win     = prio_q;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < PORTS; k++) begin
            idx = (int'(prio_q) + k) % PORTS;
            if (!win_vld && s_phv_valid[idx]) begin
                win_vld = 1'b1;
                win     = SEL_WIDTH'(idx);
            end
        end
    end

    assign in_phv   = (state_q == S_PHV);
    assign in_pkt   = (state_q == S_PKT);
    assign phv_fire = in_phv && s_phv_valid[grant_q] && m_phv_ready;
    assign pkt_end  = in_pkt && s_axis_tvalid[grant_q] && m_axis_tready && s_axis_tlast[grant_q];
    assign prio_d   = (grant_q == SEL_WIDTH'(PORTS-1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            prio_q  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (win_vld) begin
                    grant_q <= win;
                    busy_q  <= 1'b1;
                    state_q <= S_PHV;
                end
                S_PHV: if (phv_fire) state_q <= S_PKT;
                S_PKT: if (pkt_end) begin
                    prio_q  <= prio_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Data paths always follow the grant; only valid/ready are state-qualified
    assign m_phv_info    = s_phv_info[grant_q*PHV_WIDTH +: PHV_WIDTH];
    assign m_phv_valid   = in_phv && s_phv_valid[grant_q];
    assign m_axis_tdata  = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign m_axis_tkeep  = s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
    assign m_axis_tuser  = s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
    assign m_axis_tlast  = s_axis_tlast[grant_q];
    assign m_axis_tvalid = in_pkt && s_axis_tvalid[grant_q];

    always_comb begin
        s_phv_ready  = '0;
        s_axis_tready = '0;
        if (in_phv) s_phv_ready[grant_q]   = m_phv_ready;
        if (in_pkt) s_axis_tready[grant_q] = m_axis_tready;
    end

    assign grant_port = grant_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_seanet_rbttx_deparser_arb.sv
// Bench for the deparser arbiter: per-port source queues feed the DUT, an expected
// queue is filled in hand-computed grant order and a monitor pops it on every handshake.
`timescale 1ns/1ps
module tb_seanet_rbttx_deparser_arb;
    localparam int P  = 4;
    localparam int DW = 16;
    localparam int KW = 2;
    localparam int UW = 8;
    localparam int PW = 16;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [P*PW-1:0] s_phv_info;
    logic [P-1:0]    s_phv_valid, s_phv_ready;
    logic [P*DW-1:0] s_axis_tdata;
    logic [P*KW-1:0] s_axis_tkeep;
    logic [P-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [P*UW-1:0] s_axis_tuser;
    logic [PW-1:0]   m_phv_info;
    logic            m_phv_valid, m_phv_ready;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [UW-1:0]   m_axis_tuser;
    logic [SW-1:0]   grant_port;
    logic            busy;

    seanet_rbttx_deparser_arb #(
        .PORTS(P), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
        .PHV_WIDTH(PW), .SEL_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_phv_info(s_phv_info), .s_phv_valid(s_phv_valid), .s_phv_ready(s_phv_ready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_phv_info(m_phv_info), .m_phv_valid(m_phv_valid), .m_phv_ready(m_phv_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .grant_port(grant_port), .busy(busy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;
    typedef struct packed { logic [SW-1:0] port; beat_t b; } exp_beat_t;
    typedef struct packed { logic [SW-1:0] port; logic [PW-1:0] phv; } exp_phv_t;

    logic [PW-1:0] src_phv [P][$];
    beat_t         src_beat[P][$];
    exp_phv_t      exp_phv[$];
    exp_beat_t     exp_beat[$];
    logic [P-1:0]  phv_hs = '0, ax_hs = '0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic beat_t mk_beat(input int base, input int i, input int n);
        beat_t r;
        r.data = DW'(base + i);
        r.last = (i == n - 1);
        r.keep = r.last ? 2'b01 : 2'b11;
        r.user = UW'(base >> 4) ^ UW'(i);
        return r;
    endfunction

    task automatic send(input int p, input logic [PW-1:0] phv, input int n, input int base);
        src_phv[p].push_back(phv);
        for (int i = 0; i < n; i++) src_beat[p].push_back(mk_beat(base, i, n));
    endtask

    task automatic expect_pkt(input int p, input logic [PW-1:0] phv, input int n, input int base);
        exp_phv.push_back('{port: SW'(p), phv: phv});
        for (int i = 0; i < n; i++) exp_beat.push_back('{port: SW'(p), b: mk_beat(base, i, n)});
    endtask

    // Record upstream handshakes at the edge; the driver retires them on the next negedge
    always @(posedge clk) begin
        phv_hs <= s_phv_valid & s_phv_ready;
        ax_hs  <= s_axis_tvalid & s_axis_tready;
    end

    initial begin
        s_phv_info = '0; s_phv_valid = '0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < P; p++) begin
                beat_t b;
                if (phv_hs[p] && src_phv[p].size() > 0) void'(src_phv[p].pop_front());
                if (ax_hs[p] && src_beat[p].size() > 0) void'(src_beat[p].pop_front());
                s_phv_valid[p] = (src_phv[p].size() > 0);
                s_phv_info[p*PW +: PW] = (src_phv[p].size() > 0) ? src_phv[p][0] : '0;
                b = (src_beat[p].size() > 0) ? src_beat[p][0] : '0;
                s_axis_tvalid[p] = (src_beat[p].size() > 0);
                s_axis_tdata[p*DW +: DW] = b.data;
                s_axis_tkeep[p*KW +: KW] = b.keep;
                s_axis_tuser[p*UW +: UW] = b.user;
                s_axis_tlast[p] = b.last;
            end
        end
    end

    // Monitor: every offered-and-accepted output is compared against the queue head
    always begin
        logic [P-1:0] oh;
        exp_phv_t  ep;
        exp_beat_t eb;
        @(negedge clk);
        #1;
        if (rst_n) begin
            oh = P'(1) << grant_port;
            chk("tready_excl", 64'(s_axis_tready & ~oh), 64'd0);
            chk("phvready_excl", 64'(s_phv_ready & ~oh), 64'd0);
            chk("valid_excl", 64'(m_phv_valid & m_axis_tvalid), 64'd0);
            if (m_phv_valid && m_phv_ready) begin
                if (exp_phv.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_phv actual=%0h required=none", m_phv_info);
                end else begin
                    ep = exp_phv.pop_front();
                    chk("phv_port", 64'(grant_port), 64'(ep.port));
                    chk("phv_info", 64'(m_phv_info), 64'(ep.phv));
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_beat.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", m_axis_tdata);
                end else begin
                    eb = exp_beat.pop_front();
                    chk("beat_port", 64'(grant_port), 64'(eb.port));
                    chk("tdata", 64'(m_axis_tdata), 64'(eb.b.data));
                    chk("tkeep", 64'(m_axis_tkeep), 64'(eb.b.keep));
                    chk("tuser", 64'(m_axis_tuser), 64'(eb.b.user));
                    chk("tlast", 64'(m_axis_tlast), 64'(eb.b.last));
                end
            end
        end
    end

    task automatic wait_done(input string name, input int maxc);
        int c = 0;
        while ((exp_phv.size() != 0 || exp_beat.size() != 0 || busy) && c < maxc) begin
            @(posedge clk); #2;
            c++;
        end
        checks++;
        if (c >= maxc) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d pending required=0", name,
                     exp_phv.size() + exp_beat.size());
        end
    endtask

    task automatic wait_pkt(input string name, input int maxc);
        int c = 0;
        while (!m_axis_tvalid && c < maxc) begin
            @(posedge clk); #2;
            c++;
        end
        checks++;
        if (c >= maxc) begin
            errors++;
            $display("FAIL %s_nopkt actual=0 required=1", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        m_phv_ready = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_port), 64'd0);
        chk("rst_phv_valid", 64'(m_phv_valid), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Single packet from port 0; PHV must show one cycle after the request
        send(0, 16'hA5A5, 3, 16'h0100);
        expect_pkt(0, 16'hA5A5, 3, 16'h0100);
        @(negedge clk); #1;
        chk("t1_phv_early", 64'(m_phv_valid), 64'd0);
        @(negedge clk); #1;
        chk("t1_phv_valid", 64'(m_phv_valid), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_grant", 64'(grant_port), 64'd0);
        wait_done("t1", 50);
        @(posedge clk); #2;

        // Ports 0 and 1 saturate, prio=1: order 1,0,1,0
        send(0, 16'h1111, 2, 16'h0200);
        send(1, 16'h2222, 2, 16'h0300);
        send(0, 16'h1112, 2, 16'h0210);
        send(1, 16'h2223, 2, 16'h0310);
        expect_pkt(1, 16'h2222, 2, 16'h0300);
        expect_pkt(0, 16'h1111, 2, 16'h0200);
        expect_pkt(1, 16'h2223, 2, 16'h0310);
        expect_pkt(0, 16'h1112, 2, 16'h0210);
        wait_done("t2", 100);
        @(posedge clk); #2;

        // Backpressure 1,0,0,1 on a 4-beat port-1 packet while port 0 waits
        send(1, 16'h3333, 4, 16'h0400);
        send(0, 16'h3330, 1, 16'h0480);
        expect_pkt(1, 16'h3333, 4, 16'h0400);
        expect_pkt(0, 16'h3330, 1, 16'h0480);
        wait_pkt("t3", 20);
        pat = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            m_axis_tready = pat[i];
            #1;
            if (!pat[i]) begin
                chk("t3_stall_grant", 64'(grant_port), 64'd1);
                chk("t3_stall_valid", 64'(m_axis_tvalid), 64'd1);
            end
            @(posedge clk); #2;
        end
        m_axis_tready = 1'b1;
        wait_done("t3", 50);
        @(posedge clk); #2;

        // Single-beat packet on port 1 (prio=1) -> prio becomes 2
        send(1, 16'h4444, 1, 16'h0500);
        expect_pkt(1, 16'h4444, 1, 16'h0500);
        wait_done("t4", 30);
        @(posedge clk); #2;

        // Reset during beat 2 of a 5-beat port-3 packet
        send(3, 16'h5555, 5, 16'h0600);
        exp_phv.push_back('{port: 2'd3, phv: 16'h5555});
        exp_beat.push_back('{port: 2'd3, b: mk_beat(16'h0600, 0, 5)});
        wait_pkt("t5", 20);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t5_phv_valid", 64'(m_phv_valid), 64'd0);
        chk("t5_tready", 64'(s_axis_tready), 64'd0);
        chk("t5_phv_ready", 64'(s_phv_ready), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_grant", 64'(grant_port), 64'd0);
        chk("t5_beat1_seen", 64'(exp_beat.size()), 64'd0);
        for (int p = 0; p < P; p++) begin
            src_phv[p].delete();
            src_beat[p].delete();
        end
        exp_phv.delete();
        exp_beat.delete();
        @(posedge clk); #2;
        // prio must be back to 0, so port 1 beats port 3
        send(1, 16'h6666, 1, 16'h0700);
        send(3, 16'h7777, 1, 16'h0800);
        expect_pkt(1, 16'h6666, 1, 16'h0700);
        expect_pkt(3, 16'h7777, 1, 16'h0800);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_done("t5", 50);
        @(posedge clk); #2;

        // Move prio to 2, then ports 1 and 3 only: grant 3,1,3
        send(1, 16'h8888, 1, 16'h0900);
        expect_pkt(1, 16'h8888, 1, 16'h0900);
        wait_done("t6a", 30);
        @(posedge clk); #2;
        send(3, 16'h9991, 1, 16'h0A00);
        send(3, 16'h9992, 2, 16'h0A10);
        send(1, 16'h9993, 1, 16'h0B00);
        expect_pkt(3, 16'h9991, 1, 16'h0A00);
        expect_pkt(1, 16'h9993, 1, 16'h0B00);
        expect_pkt(3, 16'h9992, 2, 16'h0A10);
        wait_done("t6", 80);
        @(posedge clk); #2;

        // Last grant was 3, so prio wrapped to 0: port 0 before port 3
        send(0, 16'hAAAA, 1, 16'h0C00);
        send(3, 16'hBBBB, 1, 16'h0D00);
        expect_pkt(0, 16'hAAAA, 1, 16'h0C00);
        expect_pkt(3, 16'hBBBB, 1, 16'h0D00);
        wait_done("t7", 50);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
